// File: rtl/hack_mem_pkg.sv
// Shared region encoding and default geometry for the Hack data-memory map.
// Pure declarations: no logic, no latency, no flow control.
package hack_mem_pkg;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_SCR  = 2'd1,
      REG_KBD  = 2'd2,
      REG_NONE = 2'd3
   } region_e;

   localparam int unsigned DW_DEF         = 16;
   localparam int unsigned AW_DEF         = 15;
   localparam int unsigned RAM_AW_DEF     = 14;
   localparam int unsigned SCR_AW_DEF     = 13;
   localparam int unsigned SCR_BASE_DEF   = 'h4000;
   localparam int unsigned KBD_ADDR_DEF   = 'h6000;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/hack_mem_scr_fifo.sv
// Screen-update FIFO: head visible the cycle after push, registered count drives full/empty.
// A push is taken only when not full (pop in the same cycle does not free a slot); pop on out_vld & out_rdy.
module hack_mem_scr_fifo #(
   parameter int unsigned W     = 29,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   input  logic         out_rdy,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign do_push = in_vld && !full;
   assign do_pop  = out_rdy && !empty;
   assign out_vld = !empty;
   assign out_dat = mem[rd_ptr_q];

   // Depth is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= in_dat;
      end
   end

endmodule

// File: rtl/hack_mem_map.sv
// Hack data-memory map: RAM/screen/keyboard decode with one-cycle registered read data.
// Screen writes are mirrored into a display FIFO; a full FIFO stalls the CPU's screen write.
module hack_mem_map
   import hack_mem_pkg::*;
#(
   parameter int unsigned   DW         = DW_DEF,
   parameter int unsigned   AW         = AW_DEF,
   parameter int unsigned   RAM_AW     = RAM_AW_DEF,
   parameter int unsigned   SCR_AW     = SCR_AW_DEF,
   parameter logic [AW-1:0] SCR_BASE   = AW'(SCR_BASE_DEF),
   parameter logic [AW-1:0] KBD_ADDR   = AW'(KBD_ADDR_DEF),
   parameter int unsigned   FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DW-1:0]     in,
   input  logic              load,
   input  logic [AW-1:0]     address,
   output logic [DW-1:0]     out,
   input  logic [DW-1:0]     kbd_code,
   output logic              scr_valid,
   input  logic              scr_ready,
   output logic [SCR_AW-1:0] scr_addr,
   output logic [DW-1:0]     scr_data,
   output logic              stall,
   output logic              bus_err
);

   localparam logic [AW:0]       RAM_LIM     = (AW+1)'(2**RAM_AW);
   localparam logic [AW:0]       SCR_LO      = {1'b0, SCR_BASE};
   localparam logic [AW:0]       SCR_LIM     = SCR_LO + (AW+1)'(2**SCR_AW);
   localparam logic [SCR_AW-1:0] SCR_BASE_LO = SCR_BASE[SCR_AW-1:0];

   logic [DW-1:0] ram_mem [2**RAM_AW];
   logic [DW-1:0] scr_mem [2**SCR_AW];

   logic [DW-1:0]     out_q, out_d;
   logic [DW-1:0]     kbd_q, kbd_d;
   logic              bus_err_q, bus_err_d;

   region_e           region;
   logic [AW:0]       addr_ext;
   logic [RAM_AW-1:0] ram_idx;
   logic [SCR_AW-1:0] scr_off;
   logic              ram_we;
   logic              scr_req;
   logic              scr_we;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_out_vld;
   logic [SCR_AW+DW-1:0] fifo_out_dat;

   assign addr_ext = {1'b0, address};
   assign ram_idx  = address[RAM_AW-1:0];
   // Only the low SCR_AW bits matter for an in-window offset.
   assign scr_off  = address[SCR_AW-1:0] - SCR_BASE_LO;

   always_comb begin
      region = REG_NONE;
      if (addr_ext < RAM_LIM) begin
         region = REG_RAM;
      end else if ((addr_ext >= SCR_LO) && (addr_ext < SCR_LIM)) begin
         region = REG_SCR;
      end else if (address == KBD_ADDR) begin
         region = REG_KBD;
      end
   end

   assign ram_we  = load && (region == REG_RAM);
   assign scr_req = load && (region == REG_SCR);
   assign scr_we  = scr_req && !fifo_full;
   assign stall   = scr_req && fifo_full;

   always_comb begin
      out_d     = '0;
      kbd_d     = kbd_code;
      bus_err_d = bus_err_q;
      case (region)
         REG_RAM:  out_d = ram_mem[ram_idx];
         REG_SCR:  out_d = scr_mem[scr_off];
         REG_KBD:  out_d = kbd_q;
         default:  out_d = '0;
      endcase
      if (load && ((region == REG_KBD) || (region == REG_NONE))) begin
         bus_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         kbd_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         kbd_q     <= kbd_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Storage is not reset; the read above samples the pre-write word.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_mem[ram_idx] <= in;
      end
      if (scr_we) begin
         scr_mem[scr_off] <= in;
      end
   end

   hack_mem_scr_fifo #(
      .W     (SCR_AW + DW),
      .DEPTH (FIFO_DEPTH)
   ) u_scr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (scr_req),
      .in_dat  ({scr_off, in}),
      .out_rdy (scr_ready),
      .out_vld (fifo_out_vld),
      .out_dat (fifo_out_dat),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign scr_valid = fifo_out_vld && !fifo_empty;
   assign scr_addr  = fifo_out_dat[SCR_AW+DW-1:DW];
   assign scr_data  = fifo_out_dat[DW-1:0];
   assign out       = out_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_hack_mem_map.sv
// Bench for hack_mem_map: table vectors, backpressure/reset sequences, randomized traffic vs a model.
module tb_hack_mem_map;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic        load;
   logic [14:0] address;
   logic [15:0] out;
   logic [15:0] kbd_code;
   logic        scr_valid;
   logic        scr_ready;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;
   logic        stall;
   logic        bus_err;

   always #5 clk = ~clk;

   hack_mem_map dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (din),
      .load      (load),
      .address   (address),
      .out       (out),
      .kbd_code  (kbd_code),
      .scr_valid (scr_valid),
      .scr_ready (scr_ready),
      .scr_addr  (scr_addr),
      .scr_data  (scr_data),
      .stall     (stall),
      .bus_err   (bus_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [12:0] off;
      logic [15:0] dat;
   } ent_t;

   // Reference model state
   logic [15:0] m_ram [int];
   logic [15:0] m_scr [int];
   ent_t        m_q [$];
   logic [15:0] m_kbd;
   logic        m_bus;
   logic        last_stall;
   int          pop_log [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // 0 RAM, 1 screen, 2 keyboard, 3 unmapped
   function automatic int region(input logic [14:0] a);
      int v;
      v = int'(a);
      if (v < 16384) return 0;
      if (v < 16384 + 8192) return 1;
      if (v == 24576) return 2;
      return 3;
   endfunction

   task automatic model_reset();
      m_ram.delete();
      m_scr.delete();
      m_q.delete();
      m_kbd = '0;
      m_bus = 1'b0;
   endtask

   // One CPU cycle: drive, check combinational outputs, clock, check registered outputs.
   task automatic cycle(input logic ld, input logic [14:0] a, input logic [15:0] d,
                        input logic rdy, input logic [15:0] kc);
      int          r;
      int          off;
      bit          full;
      bit          req;
      bit          pop;
      bit          known;
      logic [15:0] exp_out;
      ent_t        e;
      load = ld; address = a; din = d; scr_ready = rdy; kbd_code = kc;
      #1;
      r    = region(a);
      off  = int'(a) - 16384;
      full = (m_q.size() == 4);
      req  = ld && (r == 1);
      chk("stall", stall, req && full);
      chk("scr_valid", scr_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk("scr_addr", scr_addr, m_q[0].off);
         chk("scr_data", scr_data, m_q[0].dat);
      end
      last_stall = stall;
      pop = (m_q.size() != 0) && rdy;
      if (pop) pop_log.push_back(int'(m_q[0].off));
      known = 1'b1;
      exp_out = '0;
      case (r)
         0: if (m_ram.exists(int'(a))) exp_out = m_ram[int'(a)]; else known = 1'b0;
         1: if (m_scr.exists(off)) exp_out = m_scr[off]; else known = 1'b0;
         2: exp_out = m_kbd;
         default: exp_out = '0;
      endcase
      @(posedge clk);
      #1;
      if (known) chk("out", out, exp_out);
      if (ld && r == 0) m_ram[int'(a)] = d;
      if (pop) void'(m_q.pop_front());
      if (req && !full) begin
         m_scr[off] = d;
         e.off = 13'(off);
         e.dat = d;
         m_q.push_back(e);
      end
      if (ld && (r == 2 || r == 3)) m_bus = 1'b1;
      m_kbd = kc;
      chk("bus_err", bus_err, m_bus);
   endtask

   typedef struct {
      logic        ld;
      logic [14:0] a;
      logic [15:0] d;
      logic        chk_out;
      logic [15:0] exp_out;
      logic        exp_err;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic        r_ld;
      logic [14:0] r_a;
      logic [15:0] r_d;
      int          sel;

      tbl[0]  = '{1'b1, 15'h0005, 16'h1234, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 15'h0005, 16'h0000, 1'b1, 16'h1234, 1'b0};
      tbl[2]  = '{1'b0, 15'h7000, 16'h0000, 1'b1, 16'h0000, 1'b0};
      tbl[3]  = '{1'b0, 15'h6000, 16'h0000, 1'b1, 16'h0041, 1'b0};
      tbl[4]  = '{1'b1, 15'h3FFF, 16'hABCD, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 15'h3FFF, 16'h0000, 1'b1, 16'hABCD, 1'b0};
      tbl[6]  = '{1'b1, 15'h4010, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{1'b0, 15'h4010, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
      tbl[8]  = '{1'b1, 15'h5FFF, 16'h0F0F, 1'b0, 16'h0000, 1'b0};
      tbl[9]  = '{1'b0, 15'h5FFF, 16'h0000, 1'b1, 16'h0F0F, 1'b0};
      tbl[10] = '{1'b0, 15'h6001, 16'h0000, 1'b1, 16'h0000, 1'b0};
      tbl[11] = '{1'b1, 15'h6000, 16'h1111, 1'b1, 16'h0041, 1'b1};
      tbl[12] = '{1'b0, 15'h0005, 16'h0000, 1'b1, 16'h1234, 1'b1};
      tbl[13] = '{1'b1, 15'h0005, 16'h5555, 1'b1, 16'h1234, 1'b1};
      tbl[14] = '{1'b0, 15'h0005, 16'h0000, 1'b1, 16'h5555, 1'b1};

      rst_n = 1'b0; load = 1'b0; address = '0; din = '0; kbd_code = '0; scr_ready = 1'b0;
      last_stall = 1'b0;
      model_reset();
      #12;
      chk("rst_out", out, 16'h0);
      chk("rst_scr_valid", scr_valid, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table vectors, with scr_ready high so the screen update drains at once
      for (int i = 0; i < 15; i++) begin
         cycle(tbl[i].ld, tbl[i].a, tbl[i].d, 1'b1, 16'h0041);
         if (tbl[i].chk_out) chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
         chk($sformatf("tbl%0d_err", i), bus_err, tbl[i].exp_err);
      end
      cycle(1'b0, 15'h0000, 16'h0, 1'b1, 16'h0041);
      chk("tbl_fifo_drained", scr_valid, 1'b0);

      // Backpressure: four writes fill the FIFO, the fifth stalls
      pop_log.delete();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 15'(16'h4000 + i), 16'(16'hA000 + i), 1'b0, 16'h0041);
         chk("bp_accept_early", last_stall, 1'b0);
      end
      cycle(1'b1, 15'h4004, 16'hA004, 1'b0, 16'h0041);
      chk("bp_stall5", last_stall, 1'b1);
      cycle(1'b1, 15'h4004, 16'hA004, 1'b1, 16'h0041);
      chk("bp_full_pop_still_stall", last_stall, 1'b1);
      cycle(1'b1, 15'h4004, 16'hA004, 1'b1, 16'h0041);
      chk("bp_fifth_accept", last_stall, 1'b0);
      for (int k = 0; k < 20 && m_q.size() != 0; k++) begin
         cycle(1'b0, 15'h4004, 16'h0, 1'b1, 16'h0041);
      end
      chk("bp_drained", scr_valid, 1'b0);
      chk("bp_pop_count", pop_log.size(), 5);
      for (int i = 0; i < 5 && i < pop_log.size(); i++) begin
         chk($sformatf("bp_order%0d", i), pop_log[i], i);
      end
      cycle(1'b0, 15'h4004, 16'h0, 1'b1, 16'h0041);
      chk("bp_readback", out, 16'hA004);

      // Randomized traffic; a stalled screen write is held until accepted
      r_ld = 1'b0; r_a = '0; r_d = '0;
      for (int n = 0; n < 600; n++) begin
         if (!last_stall) begin
            sel = $urandom_range(0, 5);
            case (sel)
               0: r_a = 15'($urandom_range(0, 7));
               1: r_a = 15'(16'h3FF8 + $urandom_range(0, 7));
               2: r_a = 15'(16'h4000 + $urandom_range(0, 7));
               3: r_a = 15'(16'h5FF8 + $urandom_range(0, 7));
               4: r_a = 15'h6000;
               default: r_a = 15'(16'h6001 + $urandom_range(0, 16'h1FFE));
            endcase
            r_ld = ($urandom_range(0, 2) != 0);
            r_d  = 16'($urandom);
         end
         cycle(r_ld, r_a, r_d, 1'($urandom_range(0, 1)), 16'($urandom));
      end

      // Reset with queued updates
      for (int k = 0; k < 20 && m_q.size() != 0; k++) begin
         cycle(1'b0, 15'h0000, 16'h0, 1'b1, 16'h0);
      end
      chk("pre_rst_empty", scr_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 15'(16'h4100 + i), 16'(16'hC000 + i), 1'b0, 16'h0);
      end
      cycle(1'b0, 15'h0005, 16'h0, 1'b0, 16'h0);
      chk("pre_rst_valid", scr_valid, 1'b1);
      load = 1'b1; address = 15'h4103; din = 16'hDEAD;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_scr_valid", scr_valid, 1'b0);
      chk("mid_rst_out", out, 16'h0);
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_bus_err", bus_err, 1'b0);
      load = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pop_log.delete();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 15'h7FFF, 16'h0, 1'b1, 16'h0);
      end
      chk("post_rst_no_pops", pop_log.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hack_mem_map.md
Name: hack_mem_map

Overview:
- Parametrised successor to the Hack data-memory map: decodes the CPU data address into RAM, screen, keyboard and unmapped regions.
- Holds RAM and screen storage internally and returns registered read data.
- Forwards every accepted screen write to an external display controller through a valid/ready FIFO, with CPU stall on backpressure.
- Sits between the CPU data port and the RAM/display/keyboard peripherals.

Parameters:
- DW, 16, data word width.
- AW, 15, CPU address width.
- RAM_AW, 14, RAM word-address width; RAM occupies 0 .. 2^RAM_AW-1.
- SCR_AW, 13, screen word-address width.
- SCR_BASE, 'h4000, first screen address; screen occupies SCR_BASE .. SCR_BASE+2^SCR_AW-1.
- KBD_ADDR, 'h6000, single keyboard register address.
- FIFO_DEPTH, 4, screen-update FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  DW  CPU write data.
- load  in  1  CPU write enable.
- address  in  AW  CPU data address.
- out  out  DW  read data, registered.
- kbd_code  in  DW  current key code from keyboard, 0 when no key.
- scr_valid  out  1  screen update available.
- scr_ready  in  1  display controller accepts update.
- scr_addr  out  SCR_AW  screen word offset of update.
- scr_data  out  DW  screen word of update.
- stall  out  1  CPU must hold the current screen write.
- bus_err  out  1  sticky illegal-write flag.

Behaviour:
- Reset (async assert, sync release): out=0, scr_valid=0, stall=0, bus_err=0, kbd register=0, FIFO empty. RAM and screen contents are undefined.
- Decode order: RAM, then screen, then KBD_ADDR. Any other address is unmapped. Comparisons are unsigned, AW bits.
- Read latency 1: out at edge N+1 reflects address at edge N.
  - RAM or screen: stored word, read-before-write if the same address is written in that cycle.
  - Keyboard: kbd register.
  - Unmapped: 0.
- kbd register samples kbd_code every cycle, so a keyboard read returns the code from 2 edges earlier.
- RAM write: load=1 in RAM region, written at the edge. Never stalled.
- Screen write: load=1 in screen region.
  - FIFO not full: screen word written, and {address-SCR_BASE, in} pushed at the same edge.
  - FIFO full: neither happens. The CPU must hold address/in/load until stall falls.
- stall = FIFO full AND a screen write is currently requested. It is combinational from the registered count; no other term.
- Push and pop in the same cycle:
  - Not full: both occur, count unchanged.
  - Full: push rejected even if a pop occurs in that cycle. The push is accepted on the next cycle.
- scr_valid = FIFO not empty. Pop when scr_valid & scr_ready.
- scr_addr/scr_data show the head entry and stay stable while scr_valid & !scr_ready.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- load=1 to KBD_ADDR or an unmapped address: no storage change; bus_err sets at the edge and stays set until reset.
- Reset mid-transfer: queued updates are discarded; scr_valid drops immediately.

Decomposition:
- Package hack_mem_pkg holds:
  - region enum: REG_RAM, REG_SCR, REG_KBD, REG_NONE;
  - default constants for widths, SCR_BASE and KBD_ADDR.
- Sub-module hack_mem_scr_fifo: synchronous valid/ready FIFO, parameters DW+SCR_AW width and FIFO_DEPTH, outputs full and empty.
- Decode and the storage arrays stay in the top module.

Test Plan:
- Reset, then write 'h1234 to 'h0005 and read 'h0005 -> out='h1234 one cycle after the read address; unmapped read 'h7000 -> out=0.
- Write 'hFFFF to 'h4010 with scr_ready=1 -> scr_valid=1 next cycle with scr_addr='h0010, scr_data='hFFFF, popped that cycle; read 'h4010 -> 'hFFFF.
- Hold scr_ready=0 and issue 5 screen writes 'h4000..'h4004 -> first 4 accepted, stall=1 on the 5th. Raise scr_ready -> 5th accepted, updates drain in order offsets 0..4.
- kbd_code='h0041 steady, read 'h6000 -> out='h0041; write to 'h6000 -> bus_err=1, persists through later traffic, cleared only by rst_n=0.
- Assert rst_n=0 with 3 queued updates -> scr_valid=0, out=0, stall=0 immediately, no spurious pops after release.
